// File: rtl/mem_responder.sv
// Unified instruction/data memory slave with a fixed programmable latency.
// Optional misaligned-access error response: define MEM_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic              acc_go;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic              wr_en;

  logic [ADDR_W-1:0] addr_idx;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign addr_idx         = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_mis;
  logic lat_mis;
  logic acc_mis;
  logic err_q;

  assign addr_mis = |addr[1:0];
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  // With LATENCY=1 the access edge is the acceptance edge, so the access
  // operands come straight from the request inputs instead of the latches.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_go    = 1'b0;
    acc_we    = lat_we;
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    acc_mis   = lat_mis;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nx    = CNT_LOAD;
          acc_we    = we;
          acc_idx   = addr_idx;
          acc_wdata = wdata;
`ifdef MEM_ALIGN_CHECK_EN
          acc_mis   = addr_mis;
`endif
          if (LATENCY == 1) begin
            state_nx = RESP;
            acc_go   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_nx   = '0;
          state_nx = RESP;
          acc_go   = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gated by Reset: the array has no reset, and a request held during reset
  // must never reach the storage.
`ifdef MEM_ALIGN_CHECK_EN
  assign wr_en = Reset & acc_go & acc_we & ~acc_mis;
`else
  assign wr_en = Reset & acc_go & acc_we;
`endif

  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      lat_mis   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ready <= (state_nx == RESP);
      busy  <= (state_nx != IDLE);
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_idx   <= addr_idx;
        lat_wdata <= wdata;
`ifdef MEM_ALIGN_CHECK_EN
        lat_mis   <= addr_mis;
`endif
      end
      if (acc_go) begin
`ifdef MEM_ALIGN_CHECK_EN
        err_q <= acc_mis;
        if (acc_mis)
          rdata <= '0;
        else if (!acc_we)
          rdata <= mem[acc_idx];
`else
        if (!acc_we)
          rdata <= mem[acc_idx];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: LATENCY=2 and LATENCY=1 instances
// compared against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [31:0] rdata_a [2];
  logic        ready_a [2];
  logic        busy_a  [2];
  logic        err_a   [2];

  int          lat_of  [2];
  logic [31:0] mem_m   [2][256];
  logic [31:0] rd_last [2];
  int          nerr;
  int          nchk;

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) u_lat2 (
    .Clk(Clk), .Reset(Reset), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
    .wdata(wdata_a[0]), .rdata(rdata_a[0]), .ready(ready_a[0]), .busy(busy_a[0]),
    .err(err_a[0])
  );

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) u_lat1 (
    .Clk(Clk), .Reset(Reset), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
    .wdata(wdata_a[1]), .rdata(rdata_a[1]), .ready(ready_a[1]), .busy(busy_a[1]),
    .err(err_a[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag, input int d);
    chk({tag, "_ready"}, 32'(ready_a[d]), 32'd0);
    chk({tag, "_busy"},  32'(busy_a[d]),  32'd0);
    chk({tag, "_err"},   32'(err_a[d]),   32'd0);
    chk({tag, "_rdata"}, rdata_a[d],      32'd0);
  endtask

  // Called right after a falling edge. exp_cyc is the number of falling
  // edges until ready: LATENCY from idle, LATENCY+1 when chained after a held req.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input int exp_cyc, input bit hold, input bit scram);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  idx;
    int          n;
    bit          got;
    req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
    idx     = a[9:2];
    exp_err = 1'b0;
    exp_rd  = rd_last[d];
`ifdef MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      exp_err = 1'b1;
      exp_rd  = '0;
    end else
`endif
    if (w) mem_m[d][idx] = wd;
    else   exp_rd = mem_m[d][idx];
    rd_last[d] = exp_rd;

    n = 0; got = 0;
    while (!got && n < exp_cyc + 4) begin
      @(negedge Clk);
      n++;
      if (ready_a[d]) got = 1;
      else if (scram && n >= exp_cyc - lat_of[d] + 1) begin
        we_a[d]    = 1'($urandom);
        addr_a[d]  = $urandom;
        wdata_a[d] = $urandom;
      end
    end
    chk("ready_cycles", 32'(n), 32'(exp_cyc));
    chk("busy_at_ready", 32'(busy_a[d]), 32'd1);
    chk("rdata", rdata_a[d], exp_rd);
    chk("err", 32'(err_a[d]), 32'(exp_err));
    if (!hold) begin
      req_a[d] = 1'b0;
      @(negedge Clk);
      chk("ready_pulse", 32'(ready_a[d]), 32'd0);
      chk("busy_idle", 32'(busy_a[d]), 32'd0);
      chk("rdata_hold", rdata_a[d], exp_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_hold;
    bit h;
    nerr = 0; nchk = 0;
    lat_of[0] = 2; lat_of[1] = 1;
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0;
      rd_last[d] = '0;
    end

    // Reset, then idle with req low.
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int d = 0; d < 2; d++) chk_quiet("in_reset", d);
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) chk_quiet("idle", d);
    end

    // Initialise every word so later reads have known expectations.
    for (int d = 0; d < 2; d++) begin
      prev_hold = 0;
      for (int i = 0; i < 256; i++) begin
        h = (i != 255) && 1'($urandom);
        txn(d, 1'b1, 32'(i) << 2, $urandom, prev_hold ? lat_of[d] + 1 : lat_of[d], h, 1'b0);
        prev_hold = h;
      end
    end

    // Directed write/read at 0x10 on the LATENCY=2 instance.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b1, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b0);

    // LATENCY=1 back-to-back reads with req held.
    txn(1, 1'b1, 32'h0, 32'h0BAD_0000, 1, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h4, 32'h0BAD_0004, 1, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b0);
    txn(1, 1'b0, 32'h4, 32'h0, 2, 1'b1, 1'b0);
    txn(1, 1'b0, 32'h0, 32'h0, 2, 1'b0, 1'b0);

    // Inputs scrambled while waiting must not affect the response.
    txn(0, 1'b1, 32'h40, 32'h5555AAAA, 2, 1'b0, 1'b1);
    txn(0, 1'b0, 32'h40, 32'h0, 2, 1'b0, 1'b1);

    // Address wrap: upper bits ignored.
    txn(0, 1'b1, 32'hFFFF_F3FC, 32'h1357_9BDF, 2, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0000_03FC, 32'h0, 2, 1'b0, 1'b0);

    // Reset in the middle of a write to 0x20.
    txn(0, 1'b1, 32'h20, 32'hA5A5_0020, 2, 1'b0, 1'b0);
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 32'h20; wdata_a[0] = 32'h12345678;
    @(negedge Clk);
    chk("mid_busy", 32'(busy_a[0]), 32'd1);
    chk("mid_ready", 32'(ready_a[0]), 32'd0);
    Reset = 1'b0;
    #1;
    req_a[0] = 1'b0;
    chk_quiet("async_reset", 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) chk_quiet("reset_hold", d);
    end
    Reset = 1'b1;
    rd_last[0] = '0; rd_last[1] = '0;
    @(negedge Clk);
    chk_quiet("after_reset", 0);
    txn(0, 1'b0, 32'h20, 32'h0, 2, 1'b0, 1'b0);

    // Misaligned write to 0x22, then read back 0x20.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 32'h22, 32'hCAFEF00D, lat_of[d], 1'b0, 1'b0);
      txn(d, 1'b0, 32'h20, 32'h0, lat_of[d], 1'b0, 1'b0);
      txn(d, 1'b0, 32'h23, 32'h0, lat_of[d], 1'b0, 1'b0);
    end

    // Random mix, including misaligned and wrapped addresses and chaining.
    for (int d = 0; d < 2; d++) begin
      prev_hold = 0;
      for (int i = 0; i < 60; i++) begin
        h = (i != 59) && 1'($urandom);
        txn(d, 1'($urandom), $urandom, $urandom,
            prev_hold ? lat_of[d] + 1 : lat_of[d], h, 1'($urandom));
        prev_hold = h;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
